// File: rtl/uart_aximaster.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// Each command becomes one AXI write or read; a per-transaction wait counter can abandon it on timeout.
module uart_aximaster #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    input  logic                            CMD_VALID,
    output logic                            CMD_READY,
    input  logic                            CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
    output logic                            RSP_VALID,
    input  logic                            RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]                      RSP_RESP,
    output logic                            RSP_TIMEOUT,
    output logic [2:0]                      dbg_state_o
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] TMO_LAST = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
    // VALID never drops before its handshake except on timeout abort, and payload is held meanwhile.

    logic [2:0]    state_q, state_d;
    logic          live_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;
    logic          rsp_tmo_q, rsp_tmo_d;

    logic cmd_hs;
    logic tmo_hit;
    logic aw_now;
    logic w_now;

    assign cmd_hs  = CMD_VALID && CMD_READY;
    // Fires on the last permitted wait cycle so the abort edge is the one where the count reaches the limit.
    assign tmo_hit = TMO_EN && (cnt_q >= TMO_LAST);
    assign aw_now  = aw_done_q || M_AXI_AWREADY;
    assign w_now   = w_done_q || M_AXI_WREADY;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_tmo_d   = rsp_tmo_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    addr_d    = CMD_ADDR;
                    wdata_d   = CMD_WDATA;
                    wstrb_d   = CMD_WSTRB;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                    rsp_tmo_d = 1'b0;
                    state_d   = CMD_WRITE ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                cnt_d     = cnt_q + 1'b1;
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    state_d = S_WR_RESP;
                end else if (tmo_hit) begin
                    state_d = S_RSP;
                end
            end
            S_WR_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (M_AXI_BVALID) begin
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    state_d     = S_RSP;
                end else if (tmo_hit) begin
                    state_d = S_RSP;
                end
            end
            S_RD_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (M_AXI_ARREADY) begin
                    state_d = S_RD_DATA;
                end else if (tmo_hit) begin
                    state_d = S_RSP;
                end
            end
            S_RD_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (M_AXI_RVALID) begin
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    state_d     = S_RSP;
                end else if (tmo_hit) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any wait state leaving for RSP without its completing handshake is a timeout abort.
        if (state_q != S_IDLE && state_q != S_RSP && state_d == S_RSP &&
            !(state_q == S_WR_RESP && M_AXI_BVALID) &&
            !(state_q == S_RD_DATA && M_AXI_RVALID)) begin
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
            rsp_tmo_d   = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            live_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    // live_q holds CMD_READY low until the first edge after reset release.
    assign CMD_READY     = live_q && (state_q == S_IDLE);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == S_RD_REQ);
    assign M_AXI_RREADY  = (state_q == S_RD_DATA);
    assign RSP_VALID     = (state_q == S_RSP);
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;
    assign RSP_TIMEOUT   = rsp_tmo_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_aximaster.sv
// Directed bench for uart_aximaster: table of complete transactions against a reactive slave,
// plus hand-timed sequences for handshake ordering, timeout, backpressure and reset abort.
module tb_uart_aximaster;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // main instance (default timeout)
    logic [AW-1:0] awaddr, araddr, cmd_addr;
    logic [2:0]    awprot, arprot, dbg_state;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata, cmd_wdata, rsp_rdata;
    logic [3:0]    wstrb, cmd_wstrb;
    logic [1:0]    bresp, rresp, rsp_resp;
    logic          cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_timeout;

    // second instance with TIMEOUT_CYCLES = 4
    logic [AW-1:0] t_awaddr, t_araddr, t_cmd_addr;
    logic [2:0]    t_awprot, t_arprot, t_dbg_state;
    logic          t_awvalid, t_awready, t_wvalid, t_wready, t_bvalid, t_bready;
    logic          t_arvalid, t_arready, t_rvalid, t_rready;
    logic [31:0]   t_wdata, t_rdata, t_cmd_wdata, t_rsp_rdata;
    logic [3:0]    t_wstrb, t_cmd_wstrb;
    logic [1:0]    t_bresp, t_rresp, t_rsp_resp;
    logic          t_cmd_valid, t_cmd_ready, t_cmd_write, t_rsp_valid, t_rsp_ready, t_rsp_timeout;

    uart_aximaster dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write), .CMD_ADDR(cmd_addr),
        .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
        .RSP_TIMEOUT(rsp_timeout), .dbg_state_o(dbg_state)
    );

    uart_aximaster #(.TIMEOUT_CYCLES(4)) dut_to (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .M_AXI_AWADDR(t_awaddr), .M_AXI_AWPROT(t_awprot), .M_AXI_AWVALID(t_awvalid), .M_AXI_AWREADY(t_awready),
        .M_AXI_WDATA(t_wdata), .M_AXI_WSTRB(t_wstrb), .M_AXI_WVALID(t_wvalid), .M_AXI_WREADY(t_wready),
        .M_AXI_BRESP(t_bresp), .M_AXI_BVALID(t_bvalid), .M_AXI_BREADY(t_bready),
        .M_AXI_ARADDR(t_araddr), .M_AXI_ARPROT(t_arprot), .M_AXI_ARVALID(t_arvalid), .M_AXI_ARREADY(t_arready),
        .M_AXI_RDATA(t_rdata), .M_AXI_RRESP(t_rresp), .M_AXI_RVALID(t_rvalid), .M_AXI_RREADY(t_rready),
        .CMD_VALID(t_cmd_valid), .CMD_READY(t_cmd_ready), .CMD_WRITE(t_cmd_write), .CMD_ADDR(t_cmd_addr),
        .CMD_WDATA(t_cmd_wdata), .CMD_WSTRB(t_cmd_wstrb),
        .RSP_VALID(t_rsp_valid), .RSP_READY(t_rsp_ready), .RSP_RDATA(t_rsp_rdata), .RSP_RESP(t_rsp_resp),
        .RSP_TIMEOUT(t_rsp_timeout), .dbg_state_o(t_dbg_state)
    );

    logic [96:0] outs_all;
    assign outs_all = {awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
                       rready, cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, dbg_state};

    int b_hs = 0;
    always @(posedge clk) if (bvalid && bready) b_hs <= b_hs + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        write;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        t_cmd_valid = 0; t_cmd_write = 0; t_cmd_addr = '0; t_cmd_wdata = '0; t_cmd_wstrb = '0; t_rsp_ready = 0;
        t_awready = 0; t_wready = 0; t_bvalid = 0; t_bresp = '0; t_arready = 0; t_rvalid = 0;
        t_rdata = '0; t_rresp = '0;
    endtask

    // Leaves the caller at the first negedge after the command handshake edge.
    task automatic issue_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        check("cmd_ready_at_issue", cmd_ready, 1);
        tick();
        cmd_valid = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit done;
        done = 0;
        issue_cmd(v.write, v.addr, v.wdata, v.wstrb);
        for (int c = 0; c < 40 && !done; c++) begin
            if (rsp_valid) begin
                check($sformatf("vec%0d_rdata", idx), rsp_rdata, v.exp_rdata);
                check($sformatf("vec%0d_resp", idx), rsp_resp, v.exp_resp);
                check($sformatf("vec%0d_timeout", idx), rsp_timeout, 0);
                rsp_ready = 1;
                tick();
                rsp_ready = 0;
                check($sformatf("vec%0d_cmd_ready_after", idx), cmd_ready, 1);
                done = 1;
            end else begin
                if (awvalid) check($sformatf("vec%0d_awaddr", idx), awaddr, v.addr);
                if (wvalid) check($sformatf("vec%0d_wdata", idx), {wstrb, wdata}, {v.wstrb, v.wdata});
                if (arvalid) check($sformatf("vec%0d_araddr", idx), araddr, v.addr);
                awready = awvalid; wready = wvalid; arready = arvalid;
                bvalid = bready; bresp = v.s_resp;
                rvalid = rready; rdata = v.s_rdata; rresp = v.s_resp;
                tick();
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rdata = '0;
            end
        end
        check($sformatf("vec%0d_completed", idx), done, 1);
    endtask

    task automatic t_run(input logic wr);
        t_cmd_write = wr; t_cmd_addr = 5'h0A; t_cmd_wdata = 32'h0BAD_F00D; t_cmd_wstrb = 4'hF; t_cmd_valid = 1;
        check("to_cmd_ready", t_cmd_ready, 1);
        tick();
        t_cmd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (wr) check($sformatf("to_wait%0d_aw_w_valid", i), {t_awvalid, t_wvalid}, 2'b11);
            else check($sformatf("to_wait%0d_arvalid", i), t_arvalid, 1);
            check($sformatf("to_wait%0d_rsp_valid", i), t_rsp_valid, 0);
            tick();
        end
        check("to_valids_low", {t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready}, 5'b0);
        check("to_rsp_valid", t_rsp_valid, 1);
        check("to_rsp_resp", t_rsp_resp, 2'b10);
        check("to_rsp_timeout", t_rsp_timeout, 1);
        check("to_rsp_rdata", t_rsp_rdata, 0);
        t_rsp_ready = 1;
        tick();
        t_rsp_ready = 0;
        check("to_cmd_ready_after", t_cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b_before;
        vecs[0] = '{1'b1, 5'h08, 32'hDEAD_BEEF, 4'h3, 32'h0,         2'b00, 32'h0,         2'b00};
        vecs[1] = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 2'b00};
        vecs[2] = '{1'b1, 5'h1C, 32'hA5A5_A5A5, 4'hF, 32'h0,         2'b10, 32'h0,         2'b10};
        vecs[3] = '{1'b0, 5'h10, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b11, 32'hCAFE_F00D, 2'b11};
        vecs[4] = '{1'b1, 5'h00, 32'h0,         4'h0, 32'h0,         2'b01, 32'h0,         2'b01};
        vecs[5] = '{1'b0, 5'h1F, 32'h0,         4'h0, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF, 2'b00};

        idle_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        @(negedge clk);
        check("reset_outputs", outs_all, 0);
        check("reset_t_cmd_ready", t_cmd_ready, 0);
        @(negedge clk);
        rst_n = 1;
        #1 check("cmd_ready_before_first_edge", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);
        check("t_cmd_ready_after_reset", t_cmd_ready, 1);

        // write 0x19 to 0x00, slave ready one cycle late, BRESP OKAY
        issue_cmd(1'b1, 5'h00, 32'h0000_0019, 4'hF);
        check("wr_c1_valids", {awvalid, wvalid}, 2'b11);
        check("wr_c1_payload", {awaddr, wstrb, wdata}, {5'h00, 4'hF, 32'h0000_0019});
        tick();
        check("wr_c2_valids", {awvalid, wvalid}, 2'b11);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        check("wr_c3_valids_dropped", {awvalid, wvalid}, 2'b00);
        check("wr_c3_bready", bready, 1);
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        check("wr_rsp", {rsp_valid, rsp_resp, rsp_rdata, rsp_timeout}, {1'b1, 2'b00, 32'h0, 1'b0});
        check("wr_rsp_bready_low", bready, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("wr_idle", {rsp_valid, cmd_ready}, 2'b01);

        // read 0x04, RVALID after three wait cycles
        issue_cmd(1'b0, 5'h04, 32'h0, 4'h0);
        check("rd_arvalid", {arvalid, araddr}, {1'b1, 5'h04});
        arready = 1;
        tick();
        arready = 0;
        check("rd_arvalid_dropped", arvalid, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd_wait%0d_rready", i), {rready, rsp_valid}, 2'b10);
            tick();
        end
        rvalid = 1; rdata = 32'h0000_000A; rresp = 2'b00;
        tick();
        rvalid = 0; rdata = '0;
        check("rd_rsp", {rsp_valid, rsp_rdata, rsp_resp, rready}, {1'b1, 32'h0000_000A, 2'b00, 1'b0});
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("rd_idle", cmd_ready, 1);

        // W accepted two cycles before AW; exactly one B handshake
        b_before = b_hs;
        issue_cmd(1'b1, 5'h14, 32'h0000_0055, 4'h5);
        check("wfirst_c1_valids", {awvalid, wvalid}, 2'b11);
        wready = 1;
        tick();
        wready = 0;
        check("wfirst_c2_valids", {awvalid, wvalid, bready}, 3'b100);
        tick();
        check("wfirst_c3_valids", {awvalid, wvalid, awaddr}, {2'b10, 5'h14});
        awready = 1;
        tick();
        awready = 0;
        check("wfirst_c4_bready", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1; bresp = 2'b00;
        tick();
        check("wfirst_rsp", {rsp_valid, rsp_resp, bready}, {1'b1, 2'b00, 1'b0});
        rsp_ready = 1;
        tick();
        rsp_ready = 0; bvalid = 0;
        check("wfirst_b_count", b_hs - b_before, 1);
        check("wfirst_idle", cmd_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        t_run(1'b1);
        t_run(1'b0);

        // response backpressure, then reset in the middle of a read
        issue_cmd(1'b0, 5'h08, 32'h0, 4'h0);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h1234_ABCD; rresp = 2'b01;
        tick();
        rvalid = 0; rdata = '0; rresp = '0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_payload", i), {rsp_valid, rsp_rdata, rsp_resp, cmd_ready},
                  {1'b1, 32'h1234_ABCD, 2'b01, 1'b0});
            tick();
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        issue_cmd(1'b0, 5'h0C, 32'h0, 4'h0);
        arready = 1;
        tick();
        arready = 0;
        check("rst_mid_rready", rready, 1);
        tick();
        rst_n = 0;
        #1 check("rst_mid_outputs_zero", outs_all, 0);
        tick();
        rvalid = 1; rdata = 32'h7777_7777;
        check("rst_held_outputs_zero", outs_all, 0);
        tick();
        rvalid = 0; rdata = '0;
        rst_n = 1;
        #1 check("rst_release_cmd_ready_low", cmd_ready, 0);
        tick();
        check("rst_release_cmd_ready", cmd_ready, 1);
        tick();
        check("rst_no_response", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
